// File: rtl/key_schedule_sequencer.sv
// Iterative AES-128 key expansion: one round key per clock into a key bank,
// served through a registered random-access read port.

module subByte (
    input  logic [31:0] word,
    output logic [31:0] subWord
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the MSB byte, so the offset is (255 - b) * 8.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    always_comb begin
        subWord = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end
endmodule

module rcon (
    input  logic [3:0]  round,
    output logic [31:0] value
);
    always_comb begin
        value = '0;
        case (round)
            4'd1:    value[31:24] = 8'h01;
            4'd2:    value[31:24] = 8'h02;
            4'd3:    value[31:24] = 8'h04;
            4'd4:    value[31:24] = 8'h08;
            4'd5:    value[31:24] = 8'h10;
            4'd6:    value[31:24] = 8'h20;
            4'd7:    value[31:24] = 8'h40;
            4'd8:    value[31:24] = 8'h80;
            4'd9:    value[31:24] = 8'h1b;
            4'd10:   value[31:24] = 8'h36;
            default: value = '0;
        endcase
    end
endmodule

module key_schedule_sequencer #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] keyInput,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rdAddr,
    output logic [127:0] rdKey,
    output logic         rdValid
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state, next_state;
    logic [3:0]   round_q;
    logic [127:0] bank [16];
    logic [15:0]  valid_q;
    logic         load;
    logic [127:0] prev_key, next_key;
    logic [31:0]  rot_word, sub_word, rc_word, t_word;
    logic [31:0]  w0, w1, w2, w3;

    always_comb load = start && (state != EXPAND);

    always_comb begin
        prev_key = bank[round_q - 4'd1];
        rot_word = {prev_key[23:0], prev_key[31:24]};
    end

    subByte u_sub (
        .word    (rot_word),
        .subWord (sub_word)
    );

    rcon u_rcon (
        .round (round_q),
        .value (rc_word)
    );

    always_comb begin
        t_word   = sub_word ^ rc_word;
        w0       = prev_key[127:96] ^ t_word;
        w1       = prev_key[95:64]  ^ w0;
        w2       = prev_key[63:32]  ^ w1;
        w3       = prev_key[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = EXPAND;
            EXPAND:  if (round_q == LAST_ROUND) next_state = DONE;
            DONE:    if (start) next_state = EXPAND;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXPAND);
        done = (state == DONE);
    end

    // Slots above NUM_ROUNDS are never written, so they stay constant zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_q <= '0;
            valid_q <= '0;
            rdKey   <= '0;
            rdValid <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) bank[i] <= '0;
        end else begin
            if (rdAddr > LAST_ROUND) begin
                rdKey   <= '0;
                rdValid <= 1'b0;
            end else begin
                rdKey   <= bank[rdAddr];
                rdValid <= valid_q[rdAddr];
            end

            if (load) begin
                bank[0] <= keyInput;
                valid_q <= 16'h0001;
                round_q <= 4'd1;
            end else if (state == EXPAND) begin
                bank[round_q]    <= next_key;
                valid_q[round_q] <= 1'b1;
                round_q          <= round_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Bench for key_schedule_sequencer: 10-round and 4-round builds checked every
// cycle against a FIPS-197 word-recurrence model, plus known-answer literals.

module tb_key_schedule_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   st;
    logic [127:0] keyInput;
    logic [3:0]   rdAddr;
    logic [1:0]   busy_o, done_o, rdv_o;
    logic [127:0] rdk0, rdk1;

    key_schedule_sequencer #(.NUM_ROUNDS(10)) u_dut10 (
        .clk(clk), .reset(reset), .start(st[0]), .keyInput(keyInput),
        .busy(busy_o[0]), .done(done_o[0]), .rdAddr(rdAddr),
        .rdKey(rdk0), .rdValid(rdv_o[0])
    );

    key_schedule_sequencer #(.NUM_ROUNDS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(st[1]), .keyInput(keyInput),
        .busy(busy_o[1]), .done(done_o[1]), .rdAddr(rdAddr),
        .rdKey(rdk1), .rdValid(rdv_o[1])
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    logic [127:0] sched_tmp [11];

    function automatic void make_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) sched_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    int           nr [2] = '{10, 4};
    logic [127:0] m_sched [2][11];
    logic [127:0] m_bank  [2][16];
    bit           m_valid [2][16];
    bit           m_zero  [2][16];
    bit           m_busy [2], m_done [2];
    int           m_t [2];
    logic [127:0] e_key [2];
    bit           e_valid [2], e_known [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int a;
            a = int'(rdAddr);
            if (reset) begin
                e_key[d] = '0; e_valid[d] = 0; e_known[d] = 1;
                for (int i = 0; i < 16; i++) begin
                    m_bank[d][i] = '0; m_valid[d][i] = 0; m_zero[d][i] = 1;
                end
                m_busy[d] = 0; m_done[d] = 0; m_t[d] = 0;
            end else begin
                if (a > nr[d]) begin
                    e_key[d] = '0; e_valid[d] = 0; e_known[d] = 1;
                end else begin
                    e_key[d]   = m_bank[d][a];
                    e_valid[d] = m_valid[d][a];
                    e_known[d] = m_valid[d][a] || m_zero[d][a];
                end
                if (st[d] && !m_busy[d]) begin
                    make_schedule(keyInput);
                    for (int r = 0; r < 11; r++) m_sched[d][r] = sched_tmp[r];
                    for (int i = 0; i < 16; i++) m_valid[d][i] = 0;
                    m_valid[d][0] = 1; m_bank[d][0] = keyInput; m_zero[d][0] = 0;
                    m_t[d] = 0; m_busy[d] = 1; m_done[d] = 0;
                end else if (m_busy[d]) begin
                    m_t[d]++;
                    m_valid[d][m_t[d]] = 1;
                    m_bank[d][m_t[d]]  = m_sched[d][m_t[d]];
                    m_zero[d][m_t[d]]  = 0;
                    if (m_t[d] == nr[d]) begin
                        m_busy[d] = 0; m_done[d] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy_n10", busy_o[0], m_busy[0]);
        check("done_n10", done_o[0], m_done[0]);
        check("rdValid_n10", rdv_o[0], e_valid[0]);
        if (e_known[0]) check("rdKey_n10", rdk0, e_key[0]);
        check("busy_n4", busy_o[1], m_busy[1]);
        check("done_n4", done_o[1], m_done[1]);
        check("rdValid_n4", rdv_o[1], e_valid[1]);
        if (e_known[1]) check("rdKey_n4", rdk1, e_key[1]);
    end

    // ---------------- stimulus ----------------
    // Driver invariant: inputs change at posedge+2; explicit checks at posedge+1.
    task automatic read_slot(input logic [3:0] a);
        rdAddr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (n < 40 && !done_o[d]) begin
            @(posedge clk); #2;
            n++;
        end
        check("wait_done", done_o[d], 1'b1);
    endtask

    initial begin
        int  cycles;
        bit  got;
        logic [7:0] inv;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        reset = 1'b1; st = 2'b00; keyInput = '0; rdAddr = '0;

        make_schedule(FIPS_KEY);
        check("model_fips_s1",  sched_tmp[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("model_fips_s4",  sched_tmp[4],  128'hef44a541a8525b7fb671253bdb0bad00);
        check("model_fips_s10", sched_tmp[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        make_schedule(SEQ_KEY);
        check("model_seq_s10",  sched_tmp[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", busy_o, 2'b00);
        check("reset_done", done_o, 2'b00);
        check("reset_rdValid", rdv_o, 2'b00);
        check("reset_rdKey", rdk0, '0);
        reset = 1'b0;

        // FIPS vector; extra start pulses mid-expansion must be ignored
        keyInput = FIPS_KEY; rdAddr = 4'd5; st = 2'b11;
        @(posedge clk); #1;
        check("e0_busy", busy_o, 2'b11);
        check("e0_done", done_o, 2'b00);
        #1;
        st = 2'b00; keyInput = {$urandom, $urandom, $urandom, $urandom};
        cycles = 0; got = 0;
        while (cycles < 30 && !got) begin
            st[0] = (cycles == 3 || cycles == 7);
            @(posedge clk); cycles++; #1;
            if (cycles <= 10) check("poll_slot5_valid", rdv_o[0], cycles >= 6);
            if (done_o[0]) got = 1;
            #1;
        end
        st = 2'b00;
        check("fips_done_latency", cycles, 10);

        read_slot(4'd1);
        check("fips_slot1", rdk0, 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_slot1_valid", rdv_o[0], 1'b1); #1;
        read_slot(4'd10);
        check("fips_slot10", rdk0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_slot10_valid", rdv_o[0], 1'b1); #1;
        read_slot(4'd0);
        check("fips_slot0", rdk0, FIPS_KEY);
        check("fips_slot0_valid", rdv_o[0], 1'b1); #1;
        read_slot(4'd12);
        check("oor12_key", rdk0, '0);
        check("oor12_valid", rdv_o, 2'b00);
        check("oor12_key_n4", rdk1, '0); #1;
        read_slot(4'd4);
        check("n4_slot4", rdk1, 128'hef44a541a8525b7fb671253bdb0bad00);
        check("n4_slot4_valid", rdv_o[1], 1'b1); #1;
        read_slot(4'd5);
        check("n4_slot5_valid", rdv_o[1], 1'b0);
        check("n4_slot5_key", rdk1, '0); #1;

        // Reset in the middle of an expansion
        keyInput = FIPS_KEY; st = 2'b11;
        @(posedge clk); #2;
        st = 2'b00;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", busy_o, 2'b00);
        check("midreset_done", done_o, 2'b00);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] a;
            a = (i == 4) ? 4'd10 : 4'(i);
            read_slot(a);
            check("midreset_rdValid", rdv_o, 2'b00);
            check("midreset_rdKey", rdk0, '0);
            check("midreset_rdKey_n4", rdk1, '0); #1;
        end
        keyInput = {$urandom, $urandom, $urandom, $urandom}; st = 2'b11;
        @(posedge clk); #2;
        st = 2'b00;
        wait_done(0);
        for (int a = 0; a < 12; a++) begin
            read_slot(4'(a)); #1;
        end

        // Restart from DONE
        keyInput = SEQ_KEY; rdAddr = 4'd9; st = 2'b11;
        @(posedge clk); #1;
        check("restart_done_drop", done_o, 2'b00);
        check("restart_busy", busy_o, 2'b11);
        #1;
        st = 2'b00;
        @(posedge clk); #2;
        @(posedge clk); #1;
        check("restart_slot9_valid", rdv_o[0], 1'b0);
        #1;
        wait_done(0);
        read_slot(4'd10);
        check("seq_slot10", rdk0, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("seq_slot10_valid", rdv_o[0], 1'b1); #1;

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            st[0]    = ($urandom_range(0, 7) == 0);
            st[1]    = ($urandom_range(0, 7) == 0);
            keyInput = {$urandom, $urandom, $urandom, $urandom};
            rdAddr   = 4'($urandom_range(0, 15));
            @(posedge clk); #2;
        end
        reset = 1'b0; st = 2'b00;
        for (int c = 0; c < 16; c++) begin
            rdAddr = 4'($urandom_range(0, 15));
            @(posedge clk); #2;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
